traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter GREEN_TIME, default 10, minimum green duration in ticks.
REQ-002 SHALL have parameter YELLOW_TIME, default 3, yellow duration in ticks.
REQ-003 SHALL have parameter ALLRED_TIME, default 2, all-red clearance duration in ticks.
REQ-004 SHALL have parameter MAX_EXT, default 5, maximum B-green extension in ticks.
REQ-005 SHALL have parameter CW, default 6, timer width; GREEN_TIME+MAX_EXT SHALL be < 2**CW and every time parameter SHALL be >= 1.
REQ-006 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port tick, input, 1, timebase enable; the timer advances only on cycles with tick=1.
REQ-009 SHALL have port sensor_b, input, 1, vehicle present on road B.
REQ-010 SHALL have port ped_req_a, input, 1, pedestrian request, crossing parallel to A.
REQ-011 SHALL have port ped_req_b, input, 1, pedestrian request, crossing parallel to B.
REQ-012 SHALL have port flash_mode, input, 1, night flashing-mode request.
REQ-013 SHALL have port light_A, output, 3, road A lamps [R,Y,G]: RED=100, YELLOW=010, GREEN=001, OFF=000.
REQ-014 SHALL have port light_B, output, 3, road B lamps, same encoding.
REQ-015 SHALL have port walk_A, output, 1, pedestrian walk signal parallel to A.
REQ-016 SHALL have port walk_B, output, 1, pedestrian walk signal parallel to B.
REQ-017 SHALL have port phase, output, 3, current state encoding.

Function
REQ-018 SHALL implement states A_GREEN=0, A_YELLOW=1, ALLRED_AB=2, B_GREEN=3, B_YELLOW=4, ALLRED_BA=5, FLASH=6; code 7 SHALL go to ALLRED_BA with timer 0 on the next clock.
REQ-019 All outputs SHALL be registered and SHALL be decoded from the next state, so lamps, walks and phase change on the same edge as the state.
REQ-020 The timer SHALL reset to 0 on every state change and otherwise increment on tick=1; all transitions other than flash entry are evaluated only on tick=1.
REQ-021 Lamps: A_GREEN A=GREEN/B=RED; A_YELLOW A=YELLOW/B=RED; B_GREEN A=RED/B=GREEN; B_YELLOW A=RED/B=YELLOW; both ALLRED states A=RED/B=RED.
REQ-022 demand_b SHALL be sensor_b OR pend_b; A_GREEN -> A_YELLOW at a tick with timer >= GREEN_TIME-1 and demand_b=1; with no demand A_GREEN SHALL rest indefinitely, timer saturating at GREEN_TIME-1.
REQ-023 A_YELLOW -> ALLRED_AB and B_YELLOW -> ALLRED_BA SHALL occur at the tick with timer == YELLOW_TIME-1.
REQ-024 ALLRED_AB -> B_GREEN and ALLRED_BA -> A_GREEN SHALL occur at the tick with timer == ALLRED_TIME-1.
REQ-025 B_GREEN -> B_YELLOW SHALL occur at the tick with timer >= GREEN_TIME-1 and sensor_b=0, or unconditionally at timer == GREEN_TIME+MAX_EXT-1 (extension cap).
REQ-026 pend_a/pend_b SHALL set on any cycle their ped_req is high; pend_a SHALL clear on entry to A_GREEN and pend_b on entry to B_GREEN; a request on the entry cycle SHALL remain pending.
REQ-027 walk_A SHALL be 1 throughout an A_GREEN visit iff pend_a was 1 at entry; walk_B likewise for B_GREEN; walks SHALL be 0 in all other states.
REQ-028 flash_mode=1 SHALL force A_GREEN -> A_YELLOW and B_GREEN -> B_YELLOW on the next clock regardless of tick or timer; yellow states continue normally.
REQ-029 In an ALLRED state whose clearance expires while flash_mode=1, the state SHALL go to FLASH instead of the next green.
REQ-030 In FLASH, walks SHALL be 0 and a toggle bit SHALL invert on each tick; light_A SHALL alternate YELLOW/OFF and light_B RED/OFF, starting YELLOW/RED at entry.
REQ-031 FLASH -> ALLRED_BA SHALL occur at the first tick with flash_mode=0; pending requests SHALL be kept across FLASH.

Reset
REQ-032 reset=0 SHALL immediately force state A_GREEN, timer 0, pend_a=pend_b=0, toggle 0, light_A=001, light_B=100, walks 0, phase=0.
REQ-033 Reset assertion mid-phase, including FLASH, SHALL abandon the phase without any yellow or all-red; after release, operation resumes from A_GREEN with a full minimum green.

Verification (GREEN_TIME=4, YELLOW_TIME=2, ALLRED_TIME=1, MAX_EXT=3, tick=1 every cycle)
REQ-034 Reset released, all inputs 0, 50 cycles -> phase stays 0, light_A=001, light_B=100.
REQ-035 sensor_b=1 held from reset release -> A_GREEN 4 cycles, A_YELLOW 2, ALLRED_AB 1, B_GREEN 7 (cap), B_YELLOW 2, ALLRED_BA 1, then repeats.
REQ-036 Single sensor_b pulse at cycle 0 -> pend_b not set, A rests; ped_req_b pulse -> B_GREEN entered with walk_B=1 for exactly 4 cycles.
REQ-037 flash_mode=1 during B_GREEN timer 1 -> B_YELLOW on the next clock, then ALLRED_BA, then FLASH with light_A 010/000 and light_B 100/000 alternating each cycle; flash_mode=0 -> ALLRED_BA, then A_GREEN.
REQ-038 tick=1 only every 3rd cycle -> every duration is exactly 3x its tick count.
REQ-039 reset=0 asynchronously mid A_YELLOW -> outputs reach reset values before the next clock edge; ped_req_a during reset is ignored.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Purpose: two-road traffic light controller with B-road sensor extension, pedestrian walks and night flash.
// Latency: all outputs are flops decoded from the next state, so lamps, walks and phase change on the state edge.
// Backpressure: none; inputs are sampled every clock and the phase timer advances only on cycles with tick=1.
module traffic_light_ctrl #(
   parameter int GREEN_TIME  = 10,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 2,
   parameter int MAX_EXT     = 5,
   parameter int CW          = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       sensor_b,
   input  logic       ped_req_a,
   input  logic       ped_req_b,
   input  logic       flash_mode,
   output logic [2:0] light_A,
   output logic [2:0] light_B,
   output logic       walk_A,
   output logic       walk_B,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      A_GREEN   = 3'd0,
      A_YELLOW  = 3'd1,
      ALLRED_AB = 3'd2,
      B_GREEN   = 3'd3,
      B_YELLOW  = 3'd4,
      ALLRED_BA = 3'd5,
      FLASH     = 3'd6
   } state_t;

   // Lamp encoding is [R,Y,G].
   localparam logic [2:0] LAMP_OFF    = 3'b000;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;

   // Timer values at which the corresponding tick ends a phase.
   localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_TIME - 1);
   localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TIME - 1);
   localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TIME - 1);
   localparam logic [CW-1:0] EXT_LAST    = CW'(GREEN_TIME + MAX_EXT - 1);
   localparam logic [CW-1:0] TIMER_ONE   = CW'(1);

   state_t          state_q,   state_d;
   logic [CW-1:0]   timer_q,   timer_d;
   logic            pend_a_q,  pend_a_d;
   logic            pend_b_q,  pend_b_d;
   logic            toggle_q,  toggle_d;
   logic [2:0]      light_a_q, light_a_d;
   logic [2:0]      light_b_q, light_b_d;
   logic            walk_a_q,  walk_a_d;
   logic            walk_b_q,  walk_b_d;

   logic            demand_b;
   logic            state_change;
   logic            enter_a_green;
   logic            enter_b_green;
   logic            enter_flash;

   // Next-state selection; flash entry from a green ignores tick, everything else waits for a tick.
   always_comb begin
      state_d  = state_q;
      demand_b = sensor_b | pend_b_q;
      case (state_q)
         A_GREEN: begin
            if (flash_mode) begin
               state_d = A_YELLOW;
            end else if (tick && (timer_q >= GREEN_LAST) && demand_b) begin
               state_d = A_YELLOW;
            end
         end
         A_YELLOW: begin
            if (tick && (timer_q == YELLOW_LAST)) begin
               state_d = ALLRED_AB;
            end
         end
         ALLRED_AB: begin
            if (tick && (timer_q == ALLRED_LAST)) begin
               state_d = flash_mode ? FLASH : B_GREEN;
            end
         end
         B_GREEN: begin
            if (flash_mode) begin
               state_d = B_YELLOW;
            end else if (tick && (((timer_q >= GREEN_LAST) && !sensor_b) || (timer_q == EXT_LAST))) begin
               state_d = B_YELLOW;
            end
         end
         B_YELLOW: begin
            if (tick && (timer_q == YELLOW_LAST)) begin
               state_d = ALLRED_BA;
            end
         end
         ALLRED_BA: begin
            if (tick && (timer_q == ALLRED_LAST)) begin
               state_d = flash_mode ? FLASH : A_GREEN;
            end
         end
         FLASH: begin
            if (tick && !flash_mode) begin
               state_d = ALLRED_BA;
            end
         end
         // Illegal code 7 recovers through a full all-red clearance.
         default: begin
            state_d = ALLRED_BA;
         end
      endcase
   end

   // Entry strobes shared by the timer, request latches and output decode.
   always_comb begin
      state_change  = (state_d != state_q);
      enter_a_green = state_change && (state_d == A_GREEN);
      enter_b_green = state_change && (state_d == B_GREEN);
      enter_flash   = state_change && (state_d == FLASH);
   end

   // Phase timer: cleared on any state change, counts ticks, parks at the end of minimum green on A.
   always_comb begin
      timer_d = timer_q;
      if (state_change) begin
         timer_d = '0;
      end else if (tick) begin
         if ((state_q == A_GREEN) && (timer_q >= GREEN_LAST)) begin
            timer_d = timer_q;
         end else begin
            timer_d = timer_q + TIMER_ONE;
         end
      end
   end

   // Pedestrian request latches; a request arriving on the entry cycle survives into the next visit.
   always_comb begin
      pend_a_d = ped_req_a | (pend_a_q & ~enter_a_green);
      pend_b_d = ped_req_b | (pend_b_q & ~enter_b_green);
   end

   // Flash blink phase: restarts lit on entry, inverts on each tick while flashing, idle-low elsewhere.
   always_comb begin
      toggle_d = 1'b0;
      if (state_d == FLASH) begin
         if (enter_flash) begin
            toggle_d = 1'b0;
         end else if (tick) begin
            toggle_d = ~toggle_q;
         end else begin
            toggle_d = toggle_q;
         end
      end
   end

   // Output decode from the next state so every output flop moves together with the state flop.
   always_comb begin
      light_a_d = LAMP_RED;
      light_b_d = LAMP_RED;
      walk_a_d  = 1'b0;
      walk_b_d  = 1'b0;
      case (state_d)
         A_GREEN: begin
            light_a_d = LAMP_GREEN;
            walk_a_d  = enter_a_green ? pend_a_q : walk_a_q;
         end
         A_YELLOW: begin
            light_a_d = LAMP_YELLOW;
         end
         B_GREEN: begin
            light_b_d = LAMP_GREEN;
            walk_b_d  = enter_b_green ? pend_b_q : walk_b_q;
         end
         B_YELLOW: begin
            light_b_d = LAMP_YELLOW;
         end
         FLASH: begin
            light_a_d = toggle_d ? LAMP_OFF : LAMP_YELLOW;
            light_b_d = toggle_d ? LAMP_OFF : LAMP_RED;
         end
         default: begin
            light_a_d = LAMP_RED;
            light_b_d = LAMP_RED;
         end
      endcase
   end

   // State, timer, request latches and registered outputs; reset drops straight into A green.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= A_GREEN;
         timer_q   <= '0;
         pend_a_q  <= 1'b0;
         pend_b_q  <= 1'b0;
         toggle_q  <= 1'b0;
         light_a_q <= LAMP_GREEN;
         light_b_q <= LAMP_RED;
         walk_a_q  <= 1'b0;
         walk_b_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pend_a_q  <= pend_a_d;
         pend_b_q  <= pend_b_d;
         toggle_q  <= toggle_d;
         light_a_q <= light_a_d;
         light_b_q <= light_b_d;
         walk_a_q  <= walk_a_d;
         walk_b_q  <= walk_b_d;
      end
   end

   assign light_A = light_a_q;
   assign light_B = light_b_q;
   assign walk_A  = walk_a_q;
   assign walk_B  = walk_b_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed, table-driven bench for traffic_light_ctrl with short timing parameters.
module tb_traffic_light_ctrl;

   localparam int GT  = 4;
   localparam int YT  = 2;
   localparam int AT  = 1;
   localparam int ME  = 3;
   localparam int CWP = 6;

   localparam logic [2:0] AG  = 3'd0;
   localparam logic [2:0] AY  = 3'd1;
   localparam logic [2:0] RAB = 3'd2;
   localparam logic [2:0] BG  = 3'd3;
   localparam logic [2:0] BY  = 3'd4;
   localparam logic [2:0] RBA = 3'd5;
   localparam logic [2:0] FL  = 3'd6;

   logic       clock;
   logic       reset;
   logic       tick;
   logic       sensor_b;
   logic       ped_req_a;
   logic       ped_req_b;
   logic       flash_mode;
   logic [2:0] light_A;
   logic [2:0] light_B;
   logic       walk_A;
   logic       walk_B;
   logic [2:0] phase;

   int n_tests = 0;
   int n_fail  = 0;

   traffic_light_ctrl #(
      .GREEN_TIME (GT),
      .YELLOW_TIME(YT),
      .ALLRED_TIME(AT),
      .MAX_EXT    (ME),
      .CW         (CWP)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick),
      .sensor_b  (sensor_b),
      .ped_req_a (ped_req_a),
      .ped_req_b (ped_req_b),
      .flash_mode(flash_mode),
      .light_A   (light_A),
      .light_B   (light_B),
      .walk_A    (walk_A),
      .walk_B    (walk_B),
      .phase     (phase)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         rst;
      bit         sb;
      bit         pa;
      bit         pb;
      bit         fl;
      int         n;
      logic [2:0] ph;
      bit         wa;
      bit         wb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(bit r, bit sb, bit pa, bit pb, bit fl, int n, logic [2:0] ph, bit wa, bit wb);
      vec_t t;
      t.rst = r;  t.sb = sb; t.pa = pa; t.pb = pb; t.fl = fl;
      t.n   = n;  t.ph = ph; t.wa = wa; t.wb = wb;
      return t;
   endfunction

   function automatic logic [2:0] exp_la(logic [2:0] ph);
      case (ph)
         AG:      return 3'b001;
         AY:      return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_lb(logic [2:0] ph);
      case (ph)
         BG:      return 3'b001;
         BY:      return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] ph, input bit wa, input bit wb);
      chk({tag, ".phase"},  int'(phase),   int'(ph));
      chk({tag, ".lightA"}, int'(light_A), int'(exp_la(ph)));
      chk({tag, ".lightB"}, int'(light_B), int'(exp_lb(ph)));
      chk({tag, ".walkA"},  int'(walk_A),  int'(wa));
      chk({tag, ".walkB"},  int'(walk_B),  int'(wb));
   endtask

   task automatic chk_flash(input string tag, input bit tog);
      chk({tag, ".phase"},  int'(phase),   int'(FL));
      chk({tag, ".lightA"}, int'(light_A), tog ? 0 : 2);
      chk({tag, ".lightB"}, int'(light_B), tog ? 0 : 4);
      chk({tag, ".walkA"},  int'(walk_A),  0);
      chk({tag, ".walkB"},  int'(walk_B),  0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".phase"},  int'(phase),   0);
      chk({tag, ".lightA"}, int'(light_A), 1);
      chk({tag, ".lightB"}, int'(light_B), 4);
      chk({tag, ".walkA"},  int'(walk_A),  0);
      chk({tag, ".walkB"},  int'(walk_B),  0);
   endtask

   task automatic do_reset(input string tag);
      reset      = 1'b0;
      tick       = 1'b1;
      sensor_b   = 1'b0;
      ped_req_a  = 1'b0;
      ped_req_b  = 1'b0;
      flash_mode = 1'b0;
      step();
      step();
      chk_reset_vals(tag);
      reset = 1'b1;
   endtask

   int          runs[$];
   logic [2:0]  rph[$];
   int          exp_len[6];
   logic [2:0]  exp_rph[6];
   logic [2:0]  seq_c[17];

   initial begin
      reset      = 1'b0;
      tick       = 1'b1;
      sensor_b   = 1'b0;
      ped_req_a  = 1'b0;
      ped_req_b  = 1'b0;
      flash_mode = 1'b0;

      // Idle: A rests with no demand.
      vecs.push_back(v(1, 0,0,0,0, 50, AG,  0,0));
      // Sensor held: full cycle with B extension capped at 7.
      vecs.push_back(v(1, 1,0,0,0, 3,  AG,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 2,  AY,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 1,  RAB, 0,0));
      vecs.push_back(v(0, 1,0,0,0, 7,  BG,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 2,  BY,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 1,  RBA, 0,0));
      vecs.push_back(v(0, 1,0,0,0, 4,  AG,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 2,  AY,  0,0));
      vecs.push_back(v(0, 1,0,0,0, 1,  RAB, 0,0));
      // Sensor pulse does not latch; ped_b pulse does; ped_a during B gives walk_A next A visit.
      vecs.push_back(v(1, 1,0,0,0, 1,  AG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 10, AG,  0,0));
      vecs.push_back(v(0, 0,0,1,0, 1,  AG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 2,  AY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RAB, 0,0));
      vecs.push_back(v(0, 0,1,0,0, 1,  BG,  0,1));
      vecs.push_back(v(0, 0,0,0,0, 3,  BG,  0,1));
      vecs.push_back(v(0, 0,0,0,0, 2,  BY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RBA, 0,0));
      vecs.push_back(v(0, 0,0,0,0, 6,  AG,  1,0));
      // Request on the B-green entry cycle stays pending for the next B visit.
      vecs.push_back(v(1, 0,0,1,0, 1,  AG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 2,  AG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 2,  AY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RAB, 0,0));
      vecs.push_back(v(0, 0,0,1,0, 1,  BG,  0,1));
      vecs.push_back(v(0, 0,0,0,0, 3,  BG,  0,1));
      vecs.push_back(v(0, 0,0,0,0, 2,  BY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RBA, 0,0));
      vecs.push_back(v(0, 0,0,0,0, 4,  AG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 2,  AY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RAB, 0,0));
      vecs.push_back(v(0, 0,0,0,0, 4,  BG,  0,1));
      // Flash in A green forces yellow at once; cleared before all-red expiry goes on to B.
      vecs.push_back(v(1, 0,0,0,1, 1,  AY,  0,0));
      vecs.push_back(v(0, 0,0,0,1, 1,  AY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RAB, 0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  BG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 3,  BG,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 2,  BY,  0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  RBA, 0,0));
      vecs.push_back(v(0, 0,0,0,0, 1,  AG,  0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset($sformatf("vec%0d.rst", i));
         sensor_b   = vecs[i].sb;
         ped_req_a  = vecs[i].pa;
         ped_req_b  = vecs[i].pb;
         flash_mode = vecs[i].fl;
         for (int c = 0; c < vecs[i].n; c++) begin
            step();
            chk_state($sformatf("vec%0d.c%0d", i, c), vecs[i].ph, vecs[i].wa, vecs[i].wb);
         end
      end

      // Flash from B green at timer 1, blinking, pending kept, then reset mid-flash.
      do_reset("fl.rst");
      sensor_b = 1'b1;
      repeat (8) step();
      chk_state("fl.bg_t1", BG, 0, 0);
      flash_mode = 1'b1;
      sensor_b   = 1'b0;
      step(); chk_state("fl.by0", BY, 0, 0);
      step(); chk_state("fl.by1", BY, 0, 0);
      step(); chk_state("fl.rba", RBA, 0, 0);
      step(); chk_flash("fl.enter", 1'b0);
      for (int i = 1; i <= 6; i++) begin
         ped_req_b = (i == 1);
         step();
         chk_flash($sformatf("fl.blink%0d", i), bit'(i % 2));
      end
      flash_mode = 1'b0;
      step(); chk_state("fl.exit_rba", RBA, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(); chk_state($sformatf("fl.ag%0d", i), AG, 0, 0);
      end
      step(); chk_state("fl.ay0", AY, 0, 0);
      step(); chk_state("fl.ay1", AY, 0, 0);
      step(); chk_state("fl.rab", RAB, 0, 0);
      step(); chk_state("fl.bg_walk", BG, 0, 1);
      flash_mode = 1'b1;
      step(); chk_state("fl.by_forced", BY, 0, 0);
      step(); chk_state("fl.by_forced1", BY, 0, 0);
      step(); chk_state("fl.rba2", RBA, 0, 0);
      step(); chk_flash("fl.enter2", 1'b0);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("fl.async_rst");
      flash_mode = 1'b0;
      step();
      chk_reset_vals("fl.rst_hold");
      reset = 1'b1;
      step(); chk_state("fl.after_rst", AG, 0, 0);

      // Tick every third cycle: each duration is three times its tick count.
      do_reset("tk.rst");
      sensor_b = 1'b1;
      begin
         logic [2:0] prev;
         int         len;
         prev = AG;
         len  = 0;
         for (int cyc = 0; cyc < 300 && runs.size() < 7; cyc++) begin
            tick = (cyc % 3 == 2);
            step();
            if (phase == prev) begin
               len++;
            end else begin
               runs.push_back(len);
               rph.push_back(prev);
               prev = phase;
               len  = 1;
            end
         end
      end
      tick = 1'b1;
      exp_len = '{6, 3, 21, 6, 3, 12};
      exp_rph = '{AY, RAB, BG, BY, RBA, AG};
      chk("tk.run_count", (runs.size() >= 7) ? 1 : 0, 1);
      if (runs.size() >= 7) begin
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("tk.run%0d.phase", i), int'(rph[i+1]), int'(exp_rph[i]));
            chk($sformatf("tk.run%0d.len", i), runs[i+1], exp_len[i]);
         end
      end

      // Async reset mid A yellow; ped_req_a while in reset must not latch.
      do_reset("ar.rst");
      sensor_b = 1'b1;
      repeat (4) step();
      chk_state("ar.ay", AY, 0, 0);
      step();
      #3;
      reset     = 1'b0;
      ped_req_a = 1'b1;
      #1;
      chk_reset_vals("ar.async");
      step();
      step();
      chk_reset_vals("ar.held");
      ped_req_a = 1'b0;
      reset     = 1'b1;
      seq_c = '{AG, AG, AG, AY, AY, RAB, BG, BG, BG, BG, BG, BG, BG, BY, BY, RBA, AG};
      for (int i = 0; i < 17; i++) begin
         step();
         chk_state($sformatf("ar.seq%0d", i), seq_c[i], 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
